// File: rtl/alu_arbiter.sv
// alu_arbiter
// -----------------------------------------------------------------------------
// Shares one external 32-bit ALU between two requesters with round-robin
// fairness. Each requester hands over an operand pair and a 4-bit ALU control
// code on a valid/ready handshake. The granted operation is driven straight to
// the ALU in the same cycle. The ALU result and zero flag are captured into a
// one-entry response buffer per requester, which is drained over a second
// valid/ready handshake.
//
// Ports
//   clk, reset                  rising-edge clock, async active-high reset
//   reqN_valid/ready            request handshake (ready == grant this cycle)
//   reqN_a, reqN_b, reqN_ctrl   operands and ALU control code
//   rspN_valid/ready            response handshake
//   rspN_result, rspN_zero      registered ALU result and zero flag
//   alu_a, alu_b, alu_ctrl      drive to the shared ALU
//   alu_result, alu_zero        return from the shared ALU
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int         WIDTH     = 32,
  parameter logic [3:0] IDLE_CTRL = 4'b1111
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_ctrl,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_ctrl,

  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,

  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  // Round-robin pointer: which requester wins when both are eligible.
  logic prio;
  logic elig0, elig1;
  logic grant0, grant1;

  // A requester may issue only if its response slot is empty or is being
  // drained this cycle, so a stalled consumer never loses a result.
  assign elig0 = req0_valid && (!rsp0_valid || rsp0_ready);
  assign elig1 = req1_valid && (!rsp1_valid || rsp1_ready);

  assign grant0 = elig0 && (!elig1 || (prio == 1'b0));
  assign grant1 = elig1 && (!elig0 || (prio == 1'b1));

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // ALU drive follows the grant; an idle cycle forces the no-op code.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = IDLE_CTRL;
    if (grant0) begin
      alu_a    = req0_a;
      alu_b    = req0_b;
      alu_ctrl = req0_ctrl;
    end else if (grant1) begin
      alu_a    = req1_a;
      alu_b    = req1_b;
      alu_ctrl = req1_ctrl;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio        <= 1'b0;
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_zero   <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      rsp1_zero   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      if (grant0)      prio <= 1'b1;
      else if (grant1) prio <= 1'b0;

      // A grant wins over a drain: the slot refills in the same cycle it
      // empties, giving one operation per cycle per requester.
      if (grant0) begin
        rsp0_valid  <= 1'b1;
        rsp0_result <= alu_result;
        rsp0_zero   <= alu_zero;
      end else if (rsp0_ready) begin
        rsp0_valid  <= 1'b0;
      end

      if (grant1) begin
        rsp1_valid  <= 1'b1;
        rsp1_result <= alu_result;
        rsp1_zero   <= alu_zero;
      end else if (rsp1_ready) begin
        rsp1_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter that shares the single 32-bit ALU between two requesters, for example the main datapath and an address/branch helper unit. Each requester issues operand pairs and a 4-bit ALU control code over a valid/ready handshake. The arbiter drives the ALU with the granted operation, registers the ALU result and zero flag into a per-requester one-entry response buffer, and returns them over a second valid/ready handshake. Together this provides one ALU operation per cycle in total, with fairness and backpressure.

## Interface
- WIDTH, 32, operand/result width (ALU is 32-bit; only 32 is supported)
- IDLE_CTRL, 4'b1111, control code driven to the ALU when nothing is granted (ALU outputs 0)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  requester N presents an operation
- req0_ready / req1_ready  out  1  operation accepted this cycle (grant)
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- req0_ctrl / req1_ctrl  in  4  ALU control: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB
- rsp0_valid / rsp1_valid  out  1  response buffer N holds a result
- rsp0_ready / rsp1_ready  in  1  requester N consumes the response
- rsp0_result / rsp1_result  out  WIDTH  registered ALU result
- rsp0_zero / rsp1_zero  out  1  registered ALU zero flag
- alu_a, alu_b  out  WIDTH  to ALU operand inputs
- alu_ctrl  out  4  to ALU control input
- alu_result  in  WIDTH  from ALU
- alu_zero  in  1  from ALU

## Operation
- Eligibility: eligN = reqN_valid && (!rspN_valid || rspN_ready). A requester whose response is still pending and not being drained is blocked.
- Grant, combinational:
  - only one requester eligible → grant it.
  - both eligible → grant the one selected by the priority pointer `prio` (0 or 1).
  - reqN_ready = grantN. At most one grant per cycle.
- Pointer: after a grant to N, `prio` ← the other requester. With no grant, `prio` holds. The result is strict alternation under continuous contention.
- ALU drive, combinational from the granted request: alu_a/alu_b/alu_ctrl = reqN_a/reqN_b/reqN_ctrl. With no grant: 0, 0, IDLE_CTRL.
- Response capture on the clock edge after a grant to N: rspN_result ← alu_result, rspN_zero ← alu_zero, rspN_valid ← 1.
- Response drain: if rspN_valid && rspN_ready with no new grant to N, then rspN_valid ← 0. Data holds its last value.
- Simultaneous drain and grant for N in the same cycle: rspN_valid stays 1 and the data is replaced by the new result (full throughput per requester).
- The zero flag is passed through unmodified. It is meaningful only for SUB (0110); for all other codes the ALU drives 0.
- Unsupported ctrl codes are forwarded unchanged. The ALU returns 0 and the response is produced normally.
- Request-side inputs may change while reqN_valid is low. While reqN_valid is high and not granted, the requester must hold them stable.

## Timing
- Reset values (asynchronous, immediate): rsp0_valid = rsp1_valid = 0, rsp*_result = 0, rsp*_zero = 0, prio = 0. req*_ready and alu_* follow the combinational rules.
- A reset asserted mid-operation discards any accepted-but-undelivered response. No partial state survives.
- Latency: request accepted in cycle T → rspN_valid high from cycle T+1.
- Throughput:
  - 1 operation per cycle aggregate.
  - A single requester with rspN_ready tied high sustains 1 operation per cycle.
  - Under full contention, each requester gets 1 operation per 2 cycles.
- Backpressure: rspN_ready low with rspN_valid high → reqN_ready low until drained. The other requester is unaffected.
- Starvation bound: an eligible requester is granted within 2 cycles.

## Test plan
- Reset → all rsp*_valid = 0, rsp*_result = 0, prio = 0; with no requests, alu_ctrl = 4'b1111, alu_a = alu_b = 0.
- req0 ADD 5 + 7 alone, rsp0_ready = 1 → req0_ready high in T; rsp0_valid, rsp0_result = 12, rsp0_zero = 0 in T+1; rsp1_valid stays 0.
- Both requesting continuously: req0 SUB 9 − 9, req1 OR 0xF0 | 0x0F → grants alternate 0, 1, 0, 1 starting with 0; rsp0 gives 0 with zero = 1, rsp1 gives 0xFF.
- rsp1_ready held low after a req1 result, both requesting → req1_ready stays low and req0 is granted every cycle. Raising rsp1_ready → req1 granted within 2 cycles.
- Simultaneous drain and new grant on port 0, back-to-back AND ops → rsp0_valid stays high and results update every cycle with no bubble.
- Reset asserted the cycle after a req0 grant → rsp0_valid drops immediately and no stale response appears after reset is released.
